// File: rtl/evaluate_castling_seq_pkg.sv
// evaluate_castling_seq_pkg: shared piece codes, board geometry, castling bit indices and square constants
// Squares are numbered rank*8+file with a1=0 and h8=63. Each square holds a PIECE_WIDTH-bit piece code.
package evaluate_castling_seq_pkg;
    localparam int PIECE_WIDTH = 4;
    localparam int BOARD_WIDTH = 64 * PIECE_WIDTH;
    // Bit 3 of a piece code marks a black piece.
    typedef enum logic [3:0] {
        EMPTY    = 4'h0,
        W_PAWN   = 4'h1,
        W_KNIGHT = 4'h2,
        W_BISHOP = 4'h3,
        W_ROOK   = 4'h4,
        W_QUEEN  = 4'h5,
        W_KING   = 4'h6,
        B_PAWN   = 4'h9,
        B_KNIGHT = 4'ha,
        B_BISHOP = 4'hb,
        B_ROOK   = 4'hc,
        B_QUEEN  = 4'hd,
        B_KING   = 4'he
    } piece_t;
    localparam int CASTLE_WS = 0;
    localparam int CASTLE_WL = 1;
    localparam int CASTLE_BS = 2;
    localparam int CASTLE_BL = 3;
    // King squares after castling, and rook home squares, per side.
    localparam int W_KING_SHORT_SQ = 6;
    localparam int W_KING_LONG_SQ  = 2;
    localparam int W_ROOK_SHORT_SQ = 7;
    localparam int W_ROOK_LONG_SQ  = 0;
    localparam int B_KING_SHORT_SQ = 62;
    localparam int B_KING_LONG_SQ  = 58;
    localparam int B_ROOK_SHORT_SQ = 63;
    localparam int B_ROOK_LONG_SQ  = 56;
    typedef enum logic [1:0] {IDLE, SCAN, MUL, OUT} state_t;
    function automatic logic [PIECE_WIDTH-1:0] piece_at(input logic [BOARD_WIDTH-1:0] b, input int sq);
        return b[sq*PIECE_WIDTH +: PIECE_WIDTH];
    endfunction
endpackage

// File: rtl/evaluate_castling_seq_if.sv
// evaluate_castling_seq_if: board input and eval output handshakes of the castling evaluator
// master: producer/consumer side (drives board_valid, board, masks, eval_ready)
// slave:  evaluator side (drives board_ready, eval_valid and the three eval terms)
interface evaluate_castling_seq_if #(parameter int EVAL_WIDTH = 32);
    import evaluate_castling_seq_pkg::*;
    logic                         board_valid;
    logic                         board_ready;
    logic [BOARD_WIDTH-1:0]       board;
    logic [3:0]                   castle_mask;
    logic [3:0]                   castle_mask_orig;
    logic                         eval_ready;
    logic                         eval_valid;
    logic signed [EVAL_WIDTH-1:0] eval_mg_white;
    logic signed [EVAL_WIDTH-1:0] eval_mg_black;
    logic signed [EVAL_WIDTH-1:0] eval_mg;
    modport master (
        output board_valid, board, castle_mask, castle_mask_orig, eval_ready,
        input  board_ready, eval_valid, eval_mg_white, eval_mg_black, eval_mg
    );
    modport slave (
        input  board_valid, board, castle_mask, castle_mask_orig, eval_ready,
        output board_ready, eval_valid, eval_mg_white, eval_mg_black, eval_mg
    );
endinterface

// File: rtl/evaluate_castling_seq_castle_side_penalty.sv
// castle_side_penalty: combinational lost-castling-right penalty for one side (result <= 0)
// board            : latched board, 64 squares x PIECE_WIDTH
// castle_mask      : rights after the move
// castle_mask_orig : rights at root
// pen              : signed penalty, 0, -PEN_ROOK_LOST or -PEN_KING_LOST
module castle_side_penalty
    import evaluate_castling_seq_pkg::*;
#(
    parameter bit WHITE_SIDE    = 1'b1,
    parameter int EVAL_WIDTH    = 32,
    parameter int PEN_ROOK_LOST = 10,
    parameter int PEN_KING_LOST = 20
) (
    input  logic [BOARD_WIDTH-1:0]       board,
    input  logic [3:0]                   castle_mask,
    input  logic [3:0]                   castle_mask_orig,
    output logic signed [EVAL_WIDTH-1:0] pen
);
    localparam int SHORT_BIT = WHITE_SIDE ? CASTLE_WS : CASTLE_BS;
    localparam int LONG_BIT  = WHITE_SIDE ? CASTLE_WL : CASTLE_BL;
    localparam int K_SHORT   = WHITE_SIDE ? W_KING_SHORT_SQ : B_KING_SHORT_SQ;
    localparam int K_LONG    = WHITE_SIDE ? W_KING_LONG_SQ : B_KING_LONG_SQ;
    localparam int R_SHORT   = WHITE_SIDE ? W_ROOK_SHORT_SQ : B_ROOK_SHORT_SQ;
    localparam int R_LONG    = WHITE_SIDE ? W_ROOK_LONG_SQ : B_ROOK_LONG_SQ;
    localparam logic [3:0] KING = WHITE_SIDE ? W_KING : B_KING;
    localparam logic [3:0] ROOK = WHITE_SIDE ? W_ROOK : B_ROOK;
    localparam logic signed [EVAL_WIDTH-1:0] NEG_ROOK = EVAL_WIDTH'(-PEN_ROOK_LOST);
    localparam logic signed [EVAL_WIDTH-1:0] NEG_KING = EVAL_WIDTH'(-PEN_KING_LOST);
    logic short_lost, long_lost;
    logic signed [EVAL_WIDTH-1:0] short_pen, long_pen;
    // Only four squares and two rights of one side are consulted; the rest is tied off here.
    logic unused_inputs;
    assign unused_inputs = ^{board, castle_mask, castle_mask_orig};
    always_comb begin
        short_lost = castle_mask_orig[SHORT_BIT] & ~castle_mask[SHORT_BIT];
        long_lost  = castle_mask_orig[LONG_BIT] & ~castle_mask[LONG_BIT];
        short_pen  = piece_at(board, K_SHORT) == KING ? NEG_ROOK :
                     piece_at(board, R_SHORT) == ROOK ? NEG_KING : '0;
        long_pen   = piece_at(board, K_LONG) == KING ? NEG_ROOK :
                     piece_at(board, R_LONG) == ROOK ? NEG_KING : '0;
        // A lost short right decides the result even when it yields 0.
        pen        = short_lost ? short_pen : long_lost ? long_pen : '0;
    end
endmodule

// File: rtl/evaluate_castling_seq.sv
// evaluate_castling_seq: handshaked multi-cycle castling evaluator scoring both colours from one board
// clk, reset : clock and asynchronous active-high reset
// bus        : slave side of evaluate_castling_seq_if (board in with ready/valid, eval terms out with ready/valid)
module evaluate_castling_seq
    import evaluate_castling_seq_pkg::*;
#(
    parameter int EVAL_WIDTH    = 32,
    parameter int SCAN_LANES    = 16,
    parameter int PEN_ROOK_LOST = 10,
    parameter int PEN_KING_LOST = 20,
    parameter int MULT_Q0       = 1,
    parameter int MULT_Q1       = 3,
    parameter int MULT_Q2       = 4
) (
    input logic                     clk,
    input logic                     reset,
    evaluate_castling_seq_if.slave  bus
);
    localparam int N_CHUNKS  = 64 / SCAN_LANES;
    localparam int CW        = N_CHUNKS > 1 ? $clog2(N_CHUNKS) : 1;
    localparam int LANE_BITS = SCAN_LANES * PIECE_WIDTH;
    localparam logic signed [EVAL_WIDTH-1:0] M0 = EVAL_WIDTH'(MULT_Q0);
    localparam logic signed [EVAL_WIDTH-1:0] M1 = EVAL_WIDTH'(MULT_Q1);
    localparam logic signed [EVAL_WIDTH-1:0] M2 = EVAL_WIDTH'(MULT_Q2);

    if (EVAL_WIDTH < 12 || !(SCAN_LANES == 8 || SCAN_LANES == 16 || SCAN_LANES == 32 || SCAN_LANES == 64)) begin : g_bad_param
        $error("evaluate_castling_seq: EVAL_WIDTH must be >= 12 and SCAN_LANES one of 8/16/32/64");
    end

    state_t                       state, state_n;
    logic [CW-1:0]                cnt;
    logic [1:0]                   qw, qb, qw_n, qb_n;
    logic [BOARD_WIDTH-1:0]       board_q;
    logic [3:0]                   mask_q, orig_q;
    logic                         board_ready_q, accept, last;
    logic [LANE_BITS-1:0]         chunk;
    logic [7:0]                   nw, nb;
    logic signed [EVAL_WIDTH-1:0] pen_w, pen_b, pen_w_q, pen_b_q;
    logic signed [EVAL_WIDTH-1:0] mw, mb, term_w, term_b;
    logic signed [EVAL_WIDTH-1:0] mgw_q, mgb_q, mg_q;

    castle_side_penalty #(
        .WHITE_SIDE(1'b1), .EVAL_WIDTH(EVAL_WIDTH),
        .PEN_ROOK_LOST(PEN_ROOK_LOST), .PEN_KING_LOST(PEN_KING_LOST)
    ) u_white (
        .board(board_q), .castle_mask(mask_q), .castle_mask_orig(orig_q), .pen(pen_w)
    );

    castle_side_penalty #(
        .WHITE_SIDE(1'b0), .EVAL_WIDTH(EVAL_WIDTH),
        .PEN_ROOK_LOST(PEN_ROOK_LOST), .PEN_KING_LOST(PEN_KING_LOST)
    ) u_black (
        .board(board_q), .castle_mask(mask_q), .castle_mask_orig(orig_q), .pen(pen_b)
    );

    // Queen census of the current chunk, folded into 2-bit counters that stick at 3.
    always_comb begin
        chunk = LANE_BITS'(board_q >> (LANE_BITS * int'(cnt)));
        nw    = '0;
        nb    = '0;
        for (int i = 0; i < SCAN_LANES; i++) begin
            nw = nw + 8'(chunk[i*PIECE_WIDTH +: PIECE_WIDTH] == W_QUEEN);
            nb = nb + 8'(chunk[i*PIECE_WIDTH +: PIECE_WIDTH] == B_QUEEN);
        end
        qw_n  = 8'(qw) + nw > 8'd3 ? 2'd3 : qw + nw[1:0];
        qb_n  = 8'(qb) + nb > 8'd3 ? 2'd3 : qb + nb[1:0];
    end

    always_comb begin
        accept  = bus.board_valid && board_ready_q;
        last    = cnt == CW'(N_CHUNKS - 1);
        state_n = state == IDLE ? (accept ? SCAN : IDLE) :
                  state == SCAN ? (last ? MUL : SCAN) :
                  state == MUL  ? OUT :
                  (bus.eval_ready ? IDLE : OUT);
        // Each side is scaled by the opponent's queen count.
        mw      = qb == 2'd0 ? M0 : qb == 2'd1 ? M1 : M2;
        mb      = qw == 2'd0 ? M0 : qw == 2'd1 ? M1 : M2;
        term_w  = pen_w_q * mw;
        term_b  = pen_b_q * mb;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            board_ready_q <= 1'b0;
            cnt           <= '0;
            qw            <= '0;
            qb            <= '0;
            board_q       <= '0;
            mask_q        <= '0;
            orig_q        <= '0;
            pen_w_q       <= '0;
            pen_b_q       <= '0;
            mgw_q         <= '0;
            mgb_q         <= '0;
            mg_q          <= '0;
        end else begin
            state         <= state_n;
            board_ready_q <= state_n == IDLE;
            if (accept) begin
                board_q <= bus.board;
                mask_q  <= bus.castle_mask;
                orig_q  <= bus.castle_mask_orig;
                cnt     <= '0;
                qw      <= '0;
                qb      <= '0;
            end
            if (state == SCAN) begin
                cnt <= cnt + CW'(1);
                qw  <= qw_n;
                qb  <= qb_n;
                if (cnt == '0) begin
                    pen_w_q <= pen_w;
                    pen_b_q <= pen_b;
                end
            end
            // Black term is reported white-relative, hence the negation.
            if (state == MUL) begin
                mgw_q <= term_w;
                mgb_q <= -term_b;
                mg_q  <= term_w - term_b;
            end
        end
    end

    assign bus.board_ready   = board_ready_q;
    assign bus.eval_valid    = state == OUT;
    assign bus.eval_mg_white = mgw_q;
    assign bus.eval_mg_black = mgb_q;
    assign bus.eval_mg       = mg_q;
endmodule

// File: tb/tb_evaluate_castling_seq.sv
// tb_evaluate_castling_seq: directed self-checking bench for evaluate_castling_seq at SCAN_LANES 16, 8 and 64
module tb_evaluate_castling_seq;
    import evaluate_castling_seq_pkg::*;
    localparam int ND = 3;
    localparam int LANES [ND] = '{16, 8, 64};
    localparam int NCH [ND]   = '{4, 8, 1};

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [BOARD_WIDTH-1:0] board;
    logic [3:0]             mask, orig;
    logic                   bv [ND];
    logic                   er [ND];
    logic                   br [ND];
    logic                   ev [ND];
    logic signed [31:0]     mgw [ND];
    logic signed [31:0]     mgb [ND];
    logic signed [31:0]     mg [ND];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        evaluate_castling_seq_if #(.EVAL_WIDTH(32)) bus ();
        assign bus.board_valid      = bv[g];
        assign bus.board            = board;
        assign bus.castle_mask      = mask;
        assign bus.castle_mask_orig = orig;
        assign bus.eval_ready       = er[g];
        assign br[g]  = bus.board_ready;
        assign ev[g]  = bus.eval_valid;
        assign mgw[g] = bus.eval_mg_white;
        assign mgb[g] = bus.eval_mg_black;
        assign mg[g]  = bus.eval_mg;
        evaluate_castling_seq #(.EVAL_WIDTH(32), .SCAN_LANES(LANES[g])) dut (
            .clk(clk),
            .reset(reset),
            .bus(bus.slave)
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [BOARD_WIDTH-1:0] put(input logic [BOARD_WIDTH-1:0] b, input int sq, input logic [3:0] p);
        b[sq*PIECE_WIDTH +: PIECE_WIDTH] = p;
        return b;
    endfunction

    function automatic logic [BOARD_WIDTH-1:0] start_pos();
        logic [BOARD_WIDTH-1:0] b;
        logic [3:0] wb [8];
        logic [3:0] bb [8];
        wb = '{W_ROOK, W_KNIGHT, W_BISHOP, W_QUEEN, W_KING, W_BISHOP, W_KNIGHT, W_ROOK};
        bb = '{B_ROOK, B_KNIGHT, B_BISHOP, B_QUEEN, B_KING, B_BISHOP, B_KNIGHT, B_ROOK};
        b = '0;
        for (int f = 0; f < 8; f++) begin
            b = put(b, f, wb[f]);
            b = put(b, 8 + f, W_PAWN);
            b = put(b, 48 + f, B_PAWN);
            b = put(b, 56 + f, bb[f]);
        end
        return b;
    endfunction

    // One full transaction: wait ready, present board, measure latency (acceptance edge counted as edge 1),
    // check the three terms, complete the output handshake and check the return to ready.
    task automatic do_job(input int d, input string tag, input logic [BOARD_WIDTH-1:0] b,
                          input logic [3:0] m, input logic [3:0] o,
                          input int ew, input int eb, input int ee, output int acc);
        int n;
        n = 0;
        while (br[d] !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check({tag, " ready"}, br[d], 1);
        board = b;
        mask = m;
        orig = o;
        bv[d] = 1'b1;
        acc = cyc;
        tick();
        bv[d] = 1'b0;
        n = 1;
        while (ev[d] !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check({tag, " latency"}, n, NCH[d] + 2);
        check({tag, " white"}, mgw[d], ew);
        check({tag, " black"}, mgb[d], eb);
        check({tag, " total"}, mg[d], ee);
        er[d] = 1'b1;
        tick();
        er[d] = 1'b0;
        check({tag, " valid drop"}, ev[d], 0);
        check({tag, " ready back"}, br[d], 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc1, acc2, dummy, n;
        logic seen;
        logic [BOARD_WIDTH-1:0] z, t2, t3a, t3b, t4, t5, t6, t7, t8, t9, t10;
        z   = '0;
        t2  = put(put(put(put(z, 6, W_KING), 5, W_ROOK), 60, B_KING), 59, B_QUEEN);
        t3a = put(put(put(z, 4, W_KING), 60, B_KING), 56, B_ROOK);
        t3b = put(put(t3a, 3, W_QUEEN), 27, W_QUEEN);
        t4  = put(put(put(put(put(z, 4, W_KING), 7, W_ROOK), 0, W_ROOK), 60, B_KING), 59, B_QUEEN);
        t5  = put(put(put(put(put(put(put(z, 6, W_KING), 60, B_KING), 59, B_QUEEN), 32, B_QUEEN), 40, B_QUEEN), 48, B_QUEEN), 63, B_QUEEN);
        t6  = put(put(put(put(z, 6, W_KING), 58, B_KING), 3, W_QUEEN), 59, B_QUEEN);
        t7  = put(put(put(z, 6, W_KING), 60, B_KING), 59, B_QUEEN);
        t8  = put(put(put(z, 2, W_KING), 3, W_ROOK), 60, B_KING);
        t9  = put(put(z, 2, W_KING), 60, B_KING);
        t10 = put(put(put(z, 62, B_KING), 4, W_KING), 3, W_QUEEN);
        for (int d = 0; d < ND; d++) begin
            bv[d] = 1'b0;
            er[d] = 1'b0;
        end
        board = '0;
        mask = '0;
        orig = '0;
        #1 reset = 1'b1;
        #2;
        for (int d = 0; d < ND; d++) begin
            check("reset ready", br[d], 0);
            check("reset valid", ev[d], 0);
            check("reset white", mgw[d], 0);
            check("reset black", mgb[d], 0);
            check("reset total", mg[d], 0);
        end
        tick();
        tick();
        reset = 1'b0;
        for (int d = 0; d < ND; d++) check("ready before first edge", br[d], 0);
        tick();
        for (int d = 0; d < ND; d++) check("ready after first edge", br[d], 1);

        for (int d = 0; d < ND; d++) begin
            do_job(d, "start", start_pos(), 4'b1111, 4'b1111, 0, 0, 0, acc1);
            do_job(d, "w short g1", t2, 4'b1110, 4'b1111, -30, 0, -30, acc2);
            check("accept spacing", acc2 - acc1, NCH[d] + 3);
            do_job(d, "b long a8 q0", t3a, 4'b0111, 4'b1111, 0, 20, 20, dummy);
            do_job(d, "b long a8 q2", t3b, 4'b0111, 4'b1111, 0, 80, 80, dummy);
            do_job(d, "w both lost", t4, 4'b1100, 4'b1111, -60, 0, -60, dummy);
            do_job(d, "queen sat", t5, 4'b1110, 4'b1111, -40, 0, -40, dummy);
            do_job(d, "both sides", t6, 4'b0110, 4'b1111, -30, 30, 0, dummy);
            do_job(d, "no orig", t7, 4'b0000, 4'b0000, 0, 0, 0, dummy);
            do_job(d, "w long c1", t8, 4'b1101, 4'b1111, -10, 0, -10, dummy);
            do_job(d, "short priority", t9, 4'b1100, 4'b1111, 0, 0, 0, dummy);
            do_job(d, "b short g8", t10, 4'b1011, 4'b1111, 0, 30, 30, dummy);
        end

        board = t2;
        mask = 4'b1110;
        orig = 4'b1111;
        bv[0] = 1'b1;
        tick();
        bv[0] = 1'b0;
        n = 1;
        while (ev[0] !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("stall valid", ev[0], 1);
        board = start_pos();
        mask = 4'b0000;
        orig = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            bv[0] = i[0];
            check("stall hold valid", ev[0], 1);
            check("stall hold white", mgw[0], -30);
            check("stall hold total", mg[0], -30);
            check("stall ready low", br[0], 0);
            tick();
        end
        bv[0] = 1'b0;
        er[0] = 1'b1;
        tick();
        er[0] = 1'b0;
        check("stall valid drop", ev[0], 0);
        check("stall ready back", br[0], 1);
        seen = 1'b0;
        for (int i = 0; i < NCH[0] + 6; i++) begin
            tick();
            if (ev[0] === 1'b1) seen = 1'b1;
        end
        check("stall pulses ignored", seen, 0);

        for (int d = 0; d < ND; d++) begin
            board = t3a;
            mask = 4'b0111;
            orig = 4'b1111;
            bv[d] = 1'b1;
            tick();
            bv[d] = 1'b0;
            tick();
            tick();
            reset = 1'b1;
            #1;
            check("abort valid", ev[d], 0);
            check("abort ready", br[d], 0);
            check("abort total", mg[d], 0);
            tick();
            reset = 1'b0;
            seen = 1'b0;
            for (int i = 0; i < 2 * NCH[d] + 6; i++) begin
                tick();
                if (ev[d] === 1'b1) seen = 1'b1;
            end
            check("abort no result", seen, 0);
            do_job(d, "after abort", t3a, 4'b0111, 4'b1111, 0, 20, 20, dummy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/evaluate_castling_seq.md
Name: evaluate_castling_seq

Overview:
Multi-cycle, handshaked castling evaluator that scores both colours from one accepted board. Successor to the single-colour fixed pipeline evaluator:
- both sides evaluated in one pass, returned as per-side terms and a combined term;
- penalties and queen multipliers are parameters;
- enemy-queen scan is time-multiplexed over SCAN_LANES squares per cycle;
- ready/valid backpressure on both input and output.

Sits beside the other mid-game evaluators feeding the eval summation tree.

Parameters:
EVAL_WIDTH, 32, signed width of all eval outputs (must be ≥ 12).
SCAN_LANES, 16, squares scanned per cycle; legal values 8, 16, 32, 64; N_CHUNKS = 64/SCAN_LANES.
PEN_ROOK_LOST, 10, magnitude when a right is lost and the king sits on that side's castled square.
PEN_KING_LOST, 20, magnitude when a right is lost, the king is not on the castled square, and the rook is on its home square.
MULT_Q0, 1, multiplier when the opponent has 0 queens.
MULT_Q1, 3, multiplier when the opponent has 1 queen.
MULT_Q2, 4, multiplier when the opponent has ≥ 2 queens.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
board_valid  in  1  board/masks valid
board_ready  out  1  block can accept a board
board  in  `BOARD_WIDTH  64 squares × `PIECE_WIDTH, square = rank*8+file
castle_mask  in  4  castling rights after the move
castle_mask_orig  in  4  castling rights at root
eval_ready  in  1  consumer accepts result
eval_valid  out  1  result valid
eval_mg_white  out  EVAL_WIDTH  white term, ≤ 0
eval_mg_black  out  EVAL_WIDTH  black term, white-relative, ≥ 0
eval_mg  out  EVAL_WIDTH  eval_mg_white + eval_mg_black

Behaviour:
- Reset (async, active-high):
  - state=IDLE; board_ready=0; eval_valid=0; all eval outputs 0; chunk counter 0; queen counts 0.
  - board_ready rises on the first clk edge after reset deasserts.
- Reset mid-operation aborts the job; no result is ever emitted for it.
- FSM states: IDLE → SCAN → MUL → OUT → IDLE.
- IDLE:
  - board_ready=1.
  - On an edge with board_valid&&board_ready: latch board and both masks, clear counts and counter, enter SCAN.
  - board_ready drops on the same edge.
- SCAN:
  - One chunk of SCAN_LANES squares per cycle, counter 0..N_CHUNKS-1.
  - Count white and black queens in separate 2-bit counters that saturate at 3.
  - The per-side penalty is computed from the latched board on the first SCAN cycle.
  - When counter == N_CHUNKS-1, enter MUL.
- Per-side penalty (side S, opponent O):
  - If orig[SHORT_S]=1 and mask[SHORT_S]=0:
    - king_S on g-file home rank → -PEN_ROOK_LOST;
    - else rook_S on h-file home rank → -PEN_KING_LOST;
    - else 0.
  - Else apply the same rule to the long side, using the c-file (king) and a-file (rook) squares.
  - Otherwise 0.
  - The short rule takes priority over the long rule, even when both rights are lost.
- MUL (one cycle):
  - term_S = pen_S × mult(queens_O).
  - eval_mg_white = term_W; eval_mg_black = -term_B; eval_mg = sum.
  - All products and sums are signed, sign-extended to EVAL_WIDTH; no saturation needed.
- OUT:
  - eval_valid=1; outputs held stable while eval_ready=0.
  - On eval_valid&&eval_ready: eval_valid→0 and return to IDLE; board_ready=1 on the next cycle.
- Latency: eval_valid rises N_CHUNKS+2 edges after the acceptance edge (6 at SCAN_LANES=16).
- Minimum spacing between accepts is N_CHUNKS+3 cycles with eval_ready tied high.
- board_valid while board_ready=0 is ignored; the producer must hold it.
- Out-of-range parameters are caught by an elaboration-time $error.

Decomposition:
- numbat.vh already holds the piece codes, `PIECE_WIDTH, `BOARD_WIDTH and `CASTLE_* bit indices.
- Add to it the king/rook home and castled square constants, so that the existing single-colour evaluator and this block share them.
- Sub-module castle_side_penalty: combinational, parameters WHITE_SIDE, EVAL_WIDTH, PEN_ROOK_LOST, PEN_KING_LOST; instantiated twice.

Test Plan:
- Start position, masks 4'b1111/4'b1111 → eval_mg=0, eval_valid at accept+6, board_ready back one cycle after eval_ready.
- White short right cleared, king g1, rook f1, one black queen → eval_mg_white=-30, eval_mg_black=0, eval_mg=-30.
- Black long right cleared, king e8, rook a8, no white queen → eval_mg_black=+20, eval_mg=+20; same board with two white queens → +80.
- White short and long rights both cleared, king e1, rooks h1/a1, one black queen → short rule wins, eval_mg_white=-60.
- eval_ready held low 10 cycles → eval_valid and outputs stable, board_ready=0 throughout, board_valid pulses ignored.
- Reset asserted during SCAN chunk 2 → eval_valid never rises; the next board is accepted and scored correctly. Repeat the suite at SCAN_LANES=8 (latency 10) and SCAN_LANES=64 (latency 3).
